// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and defaults for the data-memory arbiter.
//   state_e   : arbiter FSM states (IDLE, ACCESS, RWAIT)
//   req_id_e  : requester identity (REQ_CORE, REQ_LDR)
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RWAIT  = 2'd2
   } state_e;

   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_LDR  = 1'b1
   } req_id_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Purely combinational winner selection between the core and loader.
//   core_req_i   : core request
//   ldr_req_i    : loader request
//   last_grant_i : requester granted most recently (decides ties)
//   winner_o     : selected requester (only meaningful when a req is high)
// A single requester always wins; on a tie the requester that was not granted
// last wins. Holding last_grant_i at REQ_LDR turns this into fixed core
// priority.
// -----------------------------------------------------------------------------
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic    core_req_i,
   input  logic    ldr_req_i,
   input  req_id_e last_grant_i,
   output req_id_e winner_o
);

   always_comb begin
      winner_o = REQ_CORE;
      if (core_req_i && ldr_req_i) begin
         winner_o = (last_grant_i == REQ_CORE) ? REQ_LDR : REQ_CORE;
      end else if (ldr_req_i) begin
         winner_o = REQ_LDR;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter (core, loader/IO) in front of a single-port BRAM with
// one cycle of read latency.
//   clk, rst_n                : clock, synchronous active-low reset
//   core_req/we/addr/wdata    : core request, held until core_ack
//   core_ack                  : one-cycle pulse, core access issued
//   core_rvalid / core_rdata  : read return pulse / held read data
//   ldr_*                     : same set for the loader requester
//   wea, d_addr, wdata        : BRAM write enable, address, write data
//   rdata                     : BRAM read data (one cycle after address)
//   busy                      : high whenever the FSM is not IDLE
// Handshake: a requester raises req with we/addr/wdata and holds them until it
// sees ack high; the request is registered at grant, so changes while pending
// are taken at the grant edge and changes after the grant are ignored.
// Read data comes back as a single rvalid pulse two cycles after ack.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; without
// it the core always wins a tie.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              wea,
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy
);

   state_e              state_q, state_d;
   req_id_e             winner, win_q, last_grant;
   logic                grant;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   core_rdata_q, ldr_rdata_q;
   logic                core_rvalid_q, ldr_rvalid_q;

   assign grant = (state_q == IDLE) && (core_req || ldr_req);

   dmem_arb_pick u_pick (
      .core_req_i   (core_req),
      .ldr_req_i    (ldr_req),
      .last_grant_i (last_grant),
      .winner_o     (winner)
   );

   always_comb begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
      if (winner == REQ_LDR) begin
         sel_we    = ldr_we;
         sel_addr  = ldr_addr;
         sel_wdata = ldr_wdata;
      end
   end

`ifdef DMEM_ARB_RR_EN
   req_id_e last_q;

   // Reset value REQ_LDR lets the core win the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= REQ_LDR;
      end else if (grant) begin
         last_q <= winner;
      end
   end

   assign last_grant = last_q;
`else
   // Pinned to the loader: the picker then always resolves a tie to the core.
   assign last_grant = REQ_LDR;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (core_req || ldr_req) state_d = ACCESS;
         ACCESS:  state_d = we_q ? IDLE : RWAIT;
         RWAIT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      core_ack = 1'b0;
      ldr_ack  = 1'b0;
      wea      = 1'b0;
      busy     = (state_q != IDLE);
      if (state_q == ACCESS) begin
         core_ack = (win_q == REQ_CORE);
         ldr_ack  = (win_q == REQ_LDR);
         wea      = we_q;
      end
   end

   // ---------------- request capture and read return ----------------
   // addr_q/wdata_q drive the BRAM directly: loaded only at grant, so they
   // are valid throughout ACCESS and hold their value everywhere else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_q         <= REQ_CORE;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         core_rdata_q  <= '0;
         ldr_rdata_q   <= '0;
         core_rvalid_q <= 1'b0;
         ldr_rvalid_q  <= 1'b0;
      end else begin
         core_rvalid_q <= 1'b0;
         ldr_rvalid_q  <= 1'b0;
         if (grant) begin
            win_q   <= winner;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (state_q == RWAIT) begin
            if (win_q == REQ_CORE) begin
               core_rdata_q  <= rdata;
               core_rvalid_q <= 1'b1;
            end else begin
               ldr_rdata_q  <= rdata;
               ldr_rvalid_q <= 1'b1;
            end
         end
      end
   end

   assign d_addr      = addr_q;
   assign wdata       = wdata_q;
   assign core_rdata  = core_rdata_q;
   assign ldr_rdata   = ldr_rdata_q;
   assign core_rvalid = core_rvalid_q;
   assign ldr_rvalid  = ldr_rvalid_q;

endmodule
